game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Turn-level controller sitting between the player I/O block and the card-move datapath. Holds off requests until setup completes, then accepts one move request at a time. It screens each request for encoding legality and issues legal ones to the move datapath as a single-cycle command. It waits for completion with a timeout, tracks move statistics, and detects the won game from the foundation state.

Parameters:
MOVE_TIMEOUT, 64, cycles allowed in WAIT_MOVE before declaring a datapath hang
COUNT_W, 10, width of the move and fail counters (both saturate)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
setup_ready  in  1  deal/setup finished; level
req_valid  in  1  player move request valid
req_source  in  4  pile code: 0 talon, 1-7 tableau1-7, 8-11 foundation H/C/D/S, 12 draw-from-stock
req_offset  in  4  cards from top of source (tableau only)
req_dest  in  4  pile code, same encoding (12 not allowed)
req_ready  out  1  sequencer can accept a request this cycle
move_start  out  1  one-cycle command pulse to datapath
move_source  out  4  registered command fields, stable from move_start until done
move_offset  out  4
move_dest  out  4
move_done  in  1  datapath completion pulse
move_successful  in  1  qualifies move_done: 1 = move applied
foundation_cards  in  28  top card of each foundation, H C D S, 7 bits each
result_valid  out  1  one-cycle pulse per finished request
result_code  out  2  0 ok, 1 datapath-illegal, 2 rejected-encoding, 3 timeout
move_count  out  COUNT_W  successful moves
fail_count  out  COUNT_W  codes 1 and 2
game_won  out  1  sticky win flag
error  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state WAIT_SETUP. All outputs 0; counters 0; move_* fields 0.
- States: WAIT_SETUP, IDLE, ISSUE, WAIT_MOVE, CHECK, WON, ERROR.
- WAIT_SETUP: req_ready=0. Goes to IDLE on the first cycle setup_ready=1. Counters clear on entry.
- IDLE: req_ready=1. A request is accepted on req_valid & req_ready, and its fields are registered.
  - Rejected if: source 13-15; dest 12-15; source==dest; req_offset!=0 with a non-tableau source; source 12 with dest!=0.
  - Rejected request: next cycle result_valid=1, code 2, fail_count+1, stay IDLE. No move_start.
  - Legal request: go to ISSUE.
- ISSUE: move_start=1 for exactly one cycle (the cycle after acceptance). Go to WAIT_MOVE. Timeout counter loads 0.
- WAIT_MOVE: req_ready=0. Timeout counter increments each cycle.
  - move_done=1, move_successful=1: result code 0, move_count+1, go to CHECK.
  - move_done=1, move_successful=0: result code 1, fail_count+1, go to IDLE.
  - Counter reaches MOVE_TIMEOUT-1 without move_done: result code 3, error=1, go to ERROR.
  - move_done in the same cycle as expiry: move_done wins.
- result_valid pulses in the cycle following the deciding event.
- CHECK: one cycle. If foundation_cards == 28'hC38F2E7 (four kings, visible), set game_won and go to WON; else go to IDLE.
- WON and ERROR: terminal. req_ready=0. Leave only via reset.
- setup_ready falling in any non-terminal state aborts to WAIT_SETUP. No result pulse; move_* fields hold.
- Counters saturate at all-ones and never wrap.
- move_start is never asserted outside ISSUE. A second request cannot be accepted until result_valid has pulsed.

Decomposition:
- Shared package holds:
  - pile-code constants: TALON=0, TAB1..TAB7=1..7, FND_H/C/D/S=8..11, STOCK_DRAW=12
  - suit constants (HEARTS=00, CLUBS=01, DIAMONDS=10, SPADES=11)
  - card field widths (rank 4, suit 2, visible 1)
  - WIN_PATTERN=28'hC38F2E7
  - result-code constants and the state enum
- One natural sub-module: request_checker, purely combinational legality screen returning legal/illegal.

Test Plan:
- Reset, setup_ready=0, req_valid=1 -> req_ready=0, no result. Raise setup_ready -> req_ready=1 next cycle.
- Request src=3 off=2 dst=5; datapath move_done+successful 4 cycles after move_start -> move_start asserted exactly one cycle, fields 3/2/5, result code 0, move_count=1.
- Requests src=13; src=dst=4; src=0 off=1 -> each gives code 2 one cycle after accept, fail_count=3, move_start never asserted.
- Legal request, datapath never responds -> result code 3 at cycle MOVE_TIMEOUT after move_start, error=1, req_ready stays 0.
- Successful move with foundation_cards=28'hC38F2E7 -> CHECK then game_won=1, req_ready=0 thereafter. Same move with 28'hC38F2E6 -> back to IDLE, game_won=0.
- Drop rst mid WAIT_MOVE -> all outputs 0 immediately. Drop setup_ready mid WAIT_MOVE -> WAIT_SETUP, counters 0, no result pulse.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared constants for the game sequencer: pile codes, card layout,
// the won-game foundation pattern, result codes and FSM state encodings.
package game_sequencer_pkg;

  // Pile codes as seen on the request bus
  localparam logic [3:0] TALON      = 4'd0;
  localparam logic [3:0] TAB1       = 4'd1;
  localparam logic [3:0] TAB2       = 4'd2;
  localparam logic [3:0] TAB3       = 4'd3;
  localparam logic [3:0] TAB4       = 4'd4;
  localparam logic [3:0] TAB5       = 4'd5;
  localparam logic [3:0] TAB6       = 4'd6;
  localparam logic [3:0] TAB7       = 4'd7;
  localparam logic [3:0] FND_H      = 4'd8;
  localparam logic [3:0] FND_C      = 4'd9;
  localparam logic [3:0] FND_D      = 4'd10;
  localparam logic [3:0] FND_S      = 4'd11;
  localparam logic [3:0] STOCK_DRAW = 4'd12;

  // Suit codes
  localparam logic [1:0] HEARTS   = 2'b00;
  localparam logic [1:0] CLUBS    = 2'b01;
  localparam logic [1:0] DIAMONDS = 2'b10;
  localparam logic [1:0] SPADES   = 2'b11;

  // Card field widths: {rank, suit, visible}
  localparam int RANK_W = 4;
  localparam int SUIT_W = 2;
  localparam int VIS_W  = 1;
  localparam int CARD_W = RANK_W + SUIT_W + VIS_W;

  // All four foundations topped by a visible king (rank 12), H C D S
  localparam logic [4*CARD_W-1:0] WIN_PATTERN = 28'hC38F2E7;

  // Result codes
  localparam logic [1:0] RES_OK         = 2'd0;
  localparam logic [1:0] RES_DP_ILLEGAL = 2'd1;
  localparam logic [1:0] RES_REJECT     = 2'd2;
  localparam logic [1:0] RES_TIMEOUT    = 2'd3;

  // FSM state encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_WAIT_SETUP = 3'd0;
  localparam state_t ST_IDLE       = 3'd1;
  localparam state_t ST_ISSUE      = 3'd2;
  localparam state_t ST_WAIT_MOVE  = 3'd3;
  localparam state_t ST_CHECK      = 3'd4;
  localparam state_t ST_WON        = 3'd5;
  localparam state_t ST_ERROR      = 3'd6;

  function automatic logic is_tableau(input logic [3:0] pile);
    return (pile >= TAB1) && (pile <= TAB7);
  endfunction

endpackage

// File: rtl/game_sequencer_request_checker.sv
// Combinational legality screen for a player move request encoding.
module game_sequencer_request_checker
  import game_sequencer_pkg::*;
(
  input  logic [3:0] i_source,
  input  logic [3:0] i_offset,
  input  logic [3:0] i_dest,
  output logic       o_legal
);

  logic w_src_ok;
  logic w_dst_ok;
  logic w_distinct;
  logic w_offset_ok;
  logic w_draw_ok;

  assign w_src_ok    = (i_source <= STOCK_DRAW);
  assign w_dst_ok    = (i_dest < STOCK_DRAW);
  assign w_distinct  = (i_source != i_dest);
  // Only tableau piles can lift more than the top card
  assign w_offset_ok = (i_offset == 4'd0) || is_tableau(i_source);
  // Drawing from stock always lands on the talon
  assign w_draw_ok   = (i_source != STOCK_DRAW) || (i_dest == TALON);

  assign o_legal = w_src_ok && w_dst_ok && w_distinct && w_offset_ok && w_draw_ok;

endmodule

// File: rtl/game_sequencer.sv
// Turn-level controller: accepts one move request at a time, screens it,
// issues it to the move datapath, waits with timeout, keeps statistics and
// detects the won game.
module game_sequencer #(
  parameter int MOVE_TIMEOUT = 64,
  parameter int COUNT_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setup_ready,
  input  logic               req_valid,
  input  logic [3:0]         req_source,
  input  logic [3:0]         req_offset,
  input  logic [3:0]         req_dest,
  output logic               req_ready,
  output logic               move_start,
  output logic [3:0]         move_source,
  output logic [3:0]         move_offset,
  output logic [3:0]         move_dest,
  input  logic               move_done,
  input  logic               move_successful,
  input  logic [27:0]        foundation_cards,
  output logic               result_valid,
  output logic [1:0]         result_code,
  output logic [COUNT_W-1:0] move_count,
  output logic [COUNT_W-1:0] fail_count,
  output logic               game_won,
  output logic               error
);
  import game_sequencer_pkg::*;

  localparam int TW = $clog2(MOVE_TIMEOUT) + 1;

  state_t             r_state;
  logic [3:0]         r_src, r_off, r_dst;
  logic [TW-1:0]      r_tmo;
  logic               r_res_valid;
  logic [1:0]         r_res_code;
  logic [COUNT_W-1:0] r_move_cnt, r_fail_cnt;
  logic               r_won, r_err;

  logic          w_legal;
  logic          w_req_ready;
  logic          w_abort;
  logic          w_accept;
  logic [TW-1:0] w_tmo_next;
  logic          w_expire;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  game_sequencer_request_checker u_chk (
    .i_source (req_source),
    .i_offset (req_offset),
    .i_dest   (req_dest),
    .o_legal  (w_legal)
  );

  assign w_req_ready = (r_state == ST_IDLE);
  // Losing setup aborts any live (non-terminal) turn
  assign w_abort     = !setup_ready && (r_state != ST_WAIT_SETUP) &&
                       (r_state != ST_WON) && (r_state != ST_ERROR);
  assign w_accept    = req_valid && w_req_ready && !w_abort;
  // Expiry is the cycle in which the wait counter would step onto MOVE_TIMEOUT-1
  assign w_tmo_next  = r_tmo + 1'b1;
  assign w_expire    = (w_tmo_next == TW'(MOVE_TIMEOUT - 1));

  // Turn FSM, result pulse, statistics and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_WAIT_SETUP;
      r_res_valid <= 1'b0;
      r_res_code  <= RES_OK;
      r_move_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_won       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_WAIT_SETUP;
        r_move_cnt <= '0;
        r_fail_cnt <= '0;
      end else begin
        case (r_state)
          ST_WAIT_SETUP: if (setup_ready) r_state <= ST_IDLE;
          ST_IDLE: begin
            if (w_accept) begin
              if (w_legal) begin
                r_state <= ST_ISSUE;
              end else begin
                r_res_valid <= 1'b1;
                r_res_code  <= RES_REJECT;
                r_fail_cnt  <= sat_inc(r_fail_cnt);
              end
            end
          end
          ST_ISSUE: r_state <= ST_WAIT_MOVE;
          ST_WAIT_MOVE: begin
            // Completion takes priority over a coincident expiry
            if (move_done) begin
              r_res_valid <= 1'b1;
              if (move_successful) begin
                r_res_code <= RES_OK;
                r_move_cnt <= sat_inc(r_move_cnt);
                r_state    <= ST_CHECK;
              end else begin
                r_res_code <= RES_DP_ILLEGAL;
                r_fail_cnt <= sat_inc(r_fail_cnt);
                r_state    <= ST_IDLE;
              end
            end else if (w_expire) begin
              r_res_valid <= 1'b1;
              r_res_code  <= RES_TIMEOUT;
              r_err       <= 1'b1;
              r_state     <= ST_ERROR;
            end
          end
          ST_CHECK: begin
            if (foundation_cards == WIN_PATTERN) begin
              r_won   <= 1'b1;
              r_state <= ST_WON;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_WON, ST_ERROR: r_state <= r_state;
          default: r_state <= ST_WAIT_SETUP;
        endcase
      end
    end
  end

  // Command fields latch on acceptance; wait counter runs only in WAIT_MOVE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src <= '0;
      r_off <= '0;
      r_dst <= '0;
      r_tmo <= '0;
    end else begin
      if (w_accept) begin
        r_src <= req_source;
        r_off <= req_offset;
        r_dst <= req_dest;
      end
      if (r_state == ST_ISSUE)          r_tmo <= '0;
      else if (r_state == ST_WAIT_MOVE) r_tmo <= w_tmo_next;
    end
  end

  assign req_ready    = w_req_ready;
  assign move_start   = (r_state == ST_ISSUE);
  assign move_source  = r_src;
  assign move_offset  = r_off;
  assign move_dest    = r_dst;
  assign result_valid = r_res_valid;
  assign result_code  = r_res_code;
  assign move_count   = r_move_cnt;
  assign fail_count   = r_fail_cnt;
  assign game_won     = r_won;
  assign error        = r_err;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: the driver pushes expected results
// and issued commands; a negedge monitor pops and compares them.
module tb_game_sequencer;

  localparam int MT = 64;
  localparam int CW = 10;
  localparam logic [27:0] WIN = 28'hC38F2E7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          setup_ready = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_source = '0, req_offset = '0, req_dest = '0;
  logic          req_ready, move_start;
  logic [3:0]    move_source, move_offset, move_dest;
  logic          move_done = 1'b0, move_successful = 1'b0;
  logic [27:0]   foundation_cards = '0;
  logic          result_valid;
  logic [1:0]    result_code;
  logic [CW-1:0] move_count, fail_count;
  logic          game_won, error;

  game_sequencer #(.MOVE_TIMEOUT(MT), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst_n), .setup_ready(setup_ready),
    .req_valid(req_valid), .req_source(req_source), .req_offset(req_offset),
    .req_dest(req_dest), .req_ready(req_ready), .move_start(move_start),
    .move_source(move_source), .move_offset(move_offset), .move_dest(move_dest),
    .move_done(move_done), .move_successful(move_successful),
    .foundation_cards(foundation_cards), .result_valid(result_valid),
    .result_code(result_code), .move_count(move_count), .fail_count(fail_count),
    .game_won(game_won), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int code; int at; int mc; int fc; } exp_t;
  typedef struct { int s; int o; int d; int at; } iss_t;
  exp_t exp_q[$];
  iss_t iss_q[$];

  int n_chk = 0, n_fail = 0;
  int mc = 0, fc = 0;              // model statistics
  int dp_mode = 0;                 // 0 respond, 1 hang (timeout expected), 2 hang (aborted)
  int dp_delay = 1;
  bit dp_succ = 1'b0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Encoding rules from the pile-code table
  function automatic bit legal_move(input int s, input int o, input int d);
    bit tab = (s >= 1) && (s <= 7);
    if (s > 12 || d > 11 || s == d) return 1'b0;
    if (o != 0 && !tab) return 1'b0;
    if (s == 12 && d != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: compare every result pulse and every command pulse
  exp_t me;
  iss_t mi;
  logic prev_ms = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) begin
        if (exp_q.size() == 0) chk("result_valid_unexpected", result_valid, 0);
        else begin
          me = exp_q.pop_front();
          chk("result_code", result_code, me.code);
          chk("result_cycle", cyc, me.at);
          chk("move_count", move_count, me.mc);
          chk("fail_count", fail_count, me.fc);
        end
      end
      if (move_start) begin
        chk("move_start_width", prev_ms, 0);
        if (iss_q.size() == 0) chk("move_start_unexpected", move_start, 0);
        else begin
          mi = iss_q.pop_front();
          chk("move_source", move_source, mi.s);
          chk("move_offset", move_offset, mi.o);
          chk("move_dest", move_dest, mi.d);
          chk("move_start_cycle", cyc, mi.at);
        end
      end
    end
    prev_ms <= move_start;
  end

  // Datapath model: answers dp_delay cycles after the command pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && move_start && dp_mode == 0) begin
        repeat (dp_delay) @(negedge clk);
        move_done = 1'b1;
        move_successful = dp_succ;
        @(negedge clk);
        move_done = 1'b0;
        move_successful = 1'b0;
      end
    end
  end

  task automatic do_req(input int s, input int o, input int d, input bit sc,
                        input int dly, input int mode);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1);
    if (!req_ready) return;
    req_source = 4'(s); req_offset = 4'(o); req_dest = 4'(d);
    dp_succ = sc; dp_delay = dly; dp_mode = mode;
    if (!legal_move(s, o, d)) begin
      fc = sat(fc);
      exp_q.push_back('{2, cyc + 1, mc, fc});
    end else begin
      iss_q.push_back('{s, o, d, cyc + 1});
      if (mode == 1) exp_q.push_back('{3, cyc + 1 + MT, mc, fc});
      else if (mode == 0) begin
        if (sc) mc = sat(mc); else fc = sat(fc);
        exp_q.push_back('{sc ? 0 : 1, cyc + 2 + dly, mc, fc});
      end
    end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < MT + 200) begin
      @(negedge clk); n++;
    end
    chk(nm, exp_q.size() + iss_q.size(), 0);
    exp_q.delete(); iss_q.delete();
  endtask

  task automatic fresh_start();
    @(negedge clk);
    rst_n = 1'b0; setup_ready = 1'b0; mc = 0; fc = 0;
    exp_q.delete(); iss_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); setup_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending request and setup not done
    req_valid = 1'b1; req_source = 4'd3; req_dest = 4'd5;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_move_start", move_start, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_move_source", move_source, 0);
    chk("rst_counts", move_count + fail_count, 0);
    chk("rst_flags", {game_won, error}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(negedge clk); chk("no_setup_req_ready", req_ready, 0); end
    req_valid = 1'b0;
    setup_ready = 1'b1;
    @(negedge clk);
    chk("setup_req_ready", req_ready, 1);

    // Directed legal move, datapath answers 4 cycles after the command
    do_req(3, 2, 5, 1'b1, 4, 0);
    wait_drain("drain_directed");

    // Three encoding rejects
    do_req(13, 0, 2, 1'b0, 1, 0);
    do_req(4, 0, 4, 1'b0, 1, 0);
    do_req(0, 1, 3, 1'b0, 1, 0);
    wait_drain("drain_rejects");
    chk("fail_count_rejects", fail_count, 3);

    // Randomised mix of legal and illegal requests and datapath outcomes
    for (int k = 0; k < 80; k++) begin
      int s, o, d, dly;
      s = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 15);
      o = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
      d = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 11) : $urandom_range(0, 15);
      dly = ($urandom_range(0, 9) == 0) ? MT - 1 : $urandom_range(1, 8);
      foundation_cards = 28'($urandom);
      if (foundation_cards == WIN) foundation_cards = WIN ^ 28'h1;
      do_req(s, o, d, 1'($urandom_range(0, 1)), dly, 0);
    end
    wait_drain("drain_random");
    chk("error_after_random", error, 0);
    chk("won_after_random", game_won, 0);

    // Fail counter saturation
    for (int k = 0; k < 1030; k++) do_req(13, 0, 0, 1'b0, 1, 0);
    wait_drain("drain_saturate");
    chk("fail_count_saturated", fail_count, (1 << CW) - 1);

    // Near-win foundation: back to IDLE
    foundation_cards = 28'hC38F2E6;
    do_req(1, 0, 8, 1'b1, 2, 0);
    wait_drain("drain_nearwin");
    @(negedge clk);
    chk("nearwin_game_won", game_won, 0);
    chk("nearwin_req_ready", req_ready, 1);

    // Completion on the last cycle before expiry still counts as done
    foundation_cards = '0;
    do_req(7, 3, 2, 1'b1, MT - 1, 0);
    wait_drain("drain_late_done");
    chk("late_done_error", error, 0);

    // Winning move
    foundation_cards = WIN;
    do_req(11, 0, 4, 1'b1, 3, 0);
    wait_drain("drain_win");
    @(negedge clk);
    chk("win_game_won", game_won, 1);
    req_valid = 1'b1; req_source = 4'd2; req_offset = 4'd0; req_dest = 4'd6;
    repeat (5) begin chk("won_req_ready", req_ready, 0); @(negedge clk); end
    req_valid = 1'b0;
    chk("won_sticky", game_won, 1);
    foundation_cards = '0;

    // Asynchronous reset in the middle of WAIT_MOVE
    fresh_start();
    do_req(2, 0, 9, 1'b1, 2, 0);
    do_req(14, 0, 1, 1'b0, 1, 0);
    wait_drain("drain_pre_reset");
    do_req(5, 1, 6, 1'b0, 1, 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_move_count", move_count, 0);
    chk("midrst_fail_count", fail_count, 0);
    chk("midrst_move_fields", {move_source, move_offset, move_dest}, 0);
    chk("midrst_ctrl", {req_ready, move_start, result_valid, result_code}, 0);
    chk("midrst_flags", {game_won, error}, 0);
    mc = 0; fc = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // setup_ready falling in the middle of WAIT_MOVE
    do_req(0, 0, 3, 1'b1, 2, 0);
    do_req(12, 0, 5, 1'b0, 1, 0);
    wait_drain("drain_pre_abort");
    do_req(6, 2, 1, 1'b0, 1, 2);
    repeat (5) @(negedge clk);
    setup_ready = 1'b0; mc = 0; fc = 0;
    @(negedge clk);
    chk("abort_move_count", move_count, 0);
    chk("abort_fail_count", fail_count, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_fields_hold", {move_source, move_offset, move_dest}, {4'd6, 4'd2, 4'd1});
    repeat (10) @(negedge clk);
    setup_ready = 1'b1;
    @(negedge clk);

    // Datapath hang: timeout after MOVE_TIMEOUT cycles, terminal ERROR
    do_req(4, 0, 10, 1'b0, 1, 1);
    wait_drain("drain_timeout");
    @(negedge clk);
    chk("timeout_error", error, 1);
    req_valid = 1'b1; req_source = 4'd1; req_offset = 4'd0; req_dest = 4'd2;
    repeat (6) begin chk("error_req_ready", req_ready, 0); @(negedge clk); end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
